// File: rtl/x_addr_gen.sv
// Outer x (row) counter for the layer loop nest, with pass sequencing.
// Emits one feature-map write address per z sweep over a valid/ready handshake.
module x_addr_gen #(
  parameter int X_MAX      = 29,
  parameter int ROW_STRIDE = 30,
  parameter int BASE_ADDR  = 0,
  parameter int ADDR_W     = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4:0]        y,
  input  logic              y_zero,
  input  logic              z_zero,
  input  logic              temp_count,
  input  logic              temp_zero,
  input  logic              addr_ready,
  output logic [4:0]        x,
  output logic              x_zero,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [4:0]        x_q, x_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              addr_valid_q, addr_valid_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;

  logic stall, in_run, adv, ev, xfer, at_max;

  function automatic logic [ADDR_W-1:0] calc_addr(input logic [4:0] xv, input logic [4:0] yv);
    logic [31:0] sum;
    sum = 32'(BASE_ADDR) + 32'(xv) * 32'(ROW_STRIDE) + 32'(yv);
    return sum[ADDR_W-1:0];
  endfunction

  always_comb begin
    stall  = temp_count & ~temp_zero;
    in_run = (state_q == RUN);
    adv    = in_run & y_zero & ~stall;
    ev     = in_run & z_zero & ~stall;
    xfer   = addr_valid_q & addr_ready;
    at_max = (x_q == 5'(X_MAX));

    state_d      = state_q;
    x_d          = x_q;
    addr_d       = addr_q;
    addr_valid_d = addr_valid_q;
    done_d       = 1'b0;
    overflow_d   = overflow_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          overflow_d = 1'b0;
        end
      end
      RUN: begin
        if (adv) begin
          if (at_max) begin
            x_d     = 5'd0;
            state_d = DRAIN;
          end else begin
            x_d = x_q + 5'd1;
          end
        end
      end
      DRAIN: begin
        // Pass ends only once the last address has left or is leaving now.
        if (!addr_valid_q || addr_ready) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Address uses pre-update x; a full, stalled sink drops the new event.
    if (ev) begin
      if (!addr_valid_q || addr_ready) begin
        addr_d       = calc_addr(x_q, y);
        addr_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (xfer) begin
      addr_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      x_q          <= '0;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign x          = x_q;
  assign x_zero     = adv & at_max;
  assign addr       = addr_q;
  assign addr_valid = addr_valid_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_x_addr_gen.sv
// Bench for x_addr_gen: directed stimulus, scoreboard queue of expected addresses
// popped by an independent monitor on each accepted transfer.
module tb_x_addr_gen;

  logic        clk, rst, start;
  logic [4:0]  y;
  logic        y_zero, z_zero, temp_count, temp_zero, addr_ready;
  logic [4:0]  x;
  logic        x_zero;
  logic [11:0] addr;
  logic        addr_valid, busy, done, overflow;

  int nvec = 0;
  int nerr = 0;
  logic [11:0] sb[$];

  x_addr_gen #(.X_MAX(29), .ROW_STRIDE(30), .BASE_ADDR(0), .ADDR_W(12)) dut (
    .clk(clk), .rst(rst), .start(start), .y(y), .y_zero(y_zero), .z_zero(z_zero),
    .temp_count(temp_count), .temp_zero(temp_zero), .addr_ready(addr_ready),
    .x(x), .x_zero(x_zero), .addr(addr), .addr_valid(addr_valid),
    .busy(busy), .done(done), .overflow(overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Monitor: every accepted transfer must match the oldest expected address.
  always @(negedge clk) begin
    if (!rst && addr_valid && addr_ready) begin
      nvec++;
      if (sb.size() == 0) begin
        nerr++;
        $display("FAIL xfer_unexpected: got addr %0d expected no transfer", addr);
      end else begin
        logic [11:0] e;
        e = sb.pop_front();
        if (addr !== e) begin
          nerr++;
          $display("FAIL xfer_addr: got %0d expected %0d", addr, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_y(input int n);
    y_zero = 1'b1;
    repeat (n) tick();
    y_zero = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (done !== 1'b1 && k < 10) begin
      tick();
      k++;
    end
    chk("done_seen", {31'd0, done}, 1);
    chk("busy_at_done", {31'd0, busy}, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; y = '0; y_zero = 1'b0; z_zero = 1'b0;
    temp_count = 1'b0; temp_zero = 1'b0; addr_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset / idle
    chk("rst_x", {27'd0, x}, 0);
    chk("rst_addr", {20'd0, addr}, 0);
    chk("rst_valid", {31'd0, addr_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_ovf", {31'd0, overflow}, 0);
    y = 5'd4;
    for (int i = 0; i < 3; i++) begin
      y_zero = i[0]; z_zero = ~i[0];
      tick();
    end
    y_zero = 1'b0; z_zero = 1'b0;
    chk("idle_x", {27'd0, x}, 0);
    chk("idle_valid", {31'd0, addr_valid}, 0);
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_done", {31'd0, done}, 0);

    // Basic address at x=2, y=5
    start = 1'b1; tick(); start = 1'b0;
    chk("start_busy", {31'd0, busy}, 1);
    pulse_y(2);
    chk("basic_x", {27'd0, x}, 2);
    y = 5'd5; z_zero = 1'b1; addr_ready = 1'b1;
    sb.push_back(12'd65);
    tick();
    z_zero = 1'b0;
    chk("basic_addr", {20'd0, addr}, 65);
    chk("basic_valid", {31'd0, addr_valid}, 1);
    tick();
    chk("basic_valid_clr", {31'd0, addr_valid}, 0);
    pulse_y(28);
    wait_done();

    // Full pass
    start = 1'b1; tick(); start = 1'b0;
    y_zero = 1'b1;
    for (int i = 0; i < 30; i++) begin
      #1;
      chk("pass_x", {27'd0, x}, i);
      chk("pass_xzero", {31'd0, x_zero}, (i == 29) ? 1 : 0);
      tick();
    end
    y_zero = 1'b0;
    chk("pass_wrap_x", {27'd0, x}, 0);
    chk("pass_drain_busy", {31'd0, busy}, 1);
    chk("pass_drain_done", {31'd0, done}, 0);
    tick();
    chk("pass_done", {31'd0, done}, 1);
    chk("pass_busy_fall", {31'd0, busy}, 0);
    tick();
    chk("pass_done_once", {31'd0, done}, 0);

    // Stall at x=7, then forced wrap proceeds
    start = 1'b1; tick(); start = 1'b0;
    pulse_y(7);
    temp_count = 1'b1; temp_zero = 1'b0; y_zero = 1'b1; z_zero = 1'b1; y = 5'd3;
    tick(); tick();
    chk("stall_x", {27'd0, x}, 7);
    chk("stall_valid", {31'd0, addr_valid}, 0);
    temp_zero = 1'b1;
    sb.push_back(12'd213);
    tick();
    temp_count = 1'b0; temp_zero = 1'b0; y_zero = 1'b0; z_zero = 1'b0;
    chk("force_x", {27'd0, x}, 8);
    chk("force_addr", {20'd0, addr}, 213);
    chk("force_valid", {31'd0, addr_valid}, 1);
    tick();
    pulse_y(22);
    wait_done();

    // Backpressure and overflow
    start = 1'b1; tick(); start = 1'b0;
    pulse_y(3);
    addr_ready = 1'b0; z_zero = 1'b1; y = 5'd1;
    tick();
    chk("bp_first_addr", {20'd0, addr}, 91);
    chk("bp_first_ovf", {31'd0, overflow}, 0);
    y = 5'd4;
    tick();
    z_zero = 1'b0;
    chk("bp_hold_addr", {20'd0, addr}, 91);
    chk("bp_ovf", {31'd0, overflow}, 1);
    tick();
    chk("bp_hold_valid", {31'd0, addr_valid}, 1);
    chk("bp_hold_addr2", {20'd0, addr}, 91);
    sb.push_back(12'd91);
    addr_ready = 1'b1;
    tick();
    chk("bp_valid_clr", {31'd0, addr_valid}, 0);
    pulse_y(27);
    wait_done();
    chk("bp_ovf_sticky", {31'd0, overflow}, 1);

    // DRAIN waits for a pending address
    start = 1'b1; tick(); start = 1'b0;
    chk("ovf_cleared", {31'd0, overflow}, 0);
    pulse_y(29);
    addr_ready = 1'b0; y = 5'd2; z_zero = 1'b1; y_zero = 1'b1;
    tick();
    z_zero = 1'b0; y_zero = 1'b0;
    chk("drain_x", {27'd0, x}, 0);
    chk("drain_addr", {20'd0, addr}, 872);
    chk("drain_valid", {31'd0, addr_valid}, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drain_no_done", {31'd0, done}, 0);
      chk("drain_busy", {31'd0, busy}, 1);
    end
    sb.push_back(12'd872);
    addr_ready = 1'b1;
    tick();
    chk("drain_done", {31'd0, done}, 1);
    chk("drain_busy_fall", {31'd0, busy}, 0);
    chk("drain_valid_clr", {31'd0, addr_valid}, 0);
    tick();

    // Reset mid-pass at x=12 with an address pending
    start = 1'b1; tick(); start = 1'b0;
    pulse_y(12);
    chk("mid_x", {27'd0, x}, 12);
    addr_ready = 1'b0; z_zero = 1'b1; y = 5'd0;
    tick();
    z_zero = 1'b0;
    chk("mid_valid", {31'd0, addr_valid}, 1);
    rst = 1'b1;
    #1;
    chk("arst_x", {27'd0, x}, 0);
    chk("arst_addr", {20'd0, addr}, 0);
    chk("arst_valid", {31'd0, addr_valid}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_done", {31'd0, done}, 0);
    tick(); tick();
    rst = 1'b0; addr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_done", {31'd0, done}, 0);
      chk("post_rst_busy", {31'd0, busy}, 0);
    end

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/x_addr_gen.md
Name: x_addr_gen

Overview:
- Downstream neighbour of the y counter in the layer loop nest. Consumes y, y_zero, z_zero and the temp_count/temp_zero stall pair.
- Maintains the outer x (row) counter, sequences one layer pass with a small FSM, and emits one feature-map write address per completed z sweep.
- Address output uses a valid/ready handshake toward the output buffer writer.

Parameters:
- X_MAX, 29, last x value before wrap (x counts 0..X_MAX).
- ROW_STRIDE, 30, address increment per x step.
- BASE_ADDR, 0, address of element (x=0, y=0).
- ADDR_W, 12, address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a layer pass; honoured only in IDLE.
- y  in  5  current y count from upstream.
- y_zero  in  1  upstream y wrap (includes temp_zero forcing).
- z_zero  in  1  upstream z wrap; one address event per pulse.
- temp_count  in  1  upstream stall qualifier.
- temp_zero  in  1  upstream forced-wrap qualifier.
- addr_ready  in  1  sink accepts addr this cycle.
- x  out  5  current x count.
- x_zero  out  1  combinational: last x step of the pass is occurring this cycle.
- addr  out  ADDR_W  registered write address.
- addr_valid  out  1  addr holds an unconsumed address.
- busy  out  1  FSM not in IDLE.
- done  out  1  one-cycle pulse at end of pass.
- overflow  out  1  sticky: an address event was dropped.

Behaviour:
- Reset (async, rst=1): x=0, addr=0, addr_valid=0, done=0, overflow=0, FSM=IDLE. Reset mid-pass abandons the pass; no done is produced.
- stall = temp_count & ~temp_zero. All counting and address events are suppressed while stall=1.
- FSM states:
  - IDLE: start=1 -> RUN and clear overflow. x is already 0.
  - RUN: on every adv cycle, if x==X_MAX then x<=0 and go to DRAIN, else x<=x+1. adv = y_zero & ~stall.
  - DRAIN: wait until addr_valid==0 or (addr_valid & addr_ready). Then assert done for exactly one cycle and go to IDLE.
- start is ignored outside IDLE.
- Outside RUN, y_zero and z_zero are ignored.
- x_zero = RUN & adv & (x==X_MAX).
- busy = (state != IDLE).
- Address event:
  - ev = RUN & z_zero & ~stall.
  - Computed from pre-update x and y: BASE_ADDR + x*ROW_STRIDE + y, truncated mod 2^ADDR_W.
  - Latency: addr and addr_valid are registered and appear 1 cycle after ev.
- Handshake:
  - A transfer occurs on any cycle with addr_valid & addr_ready.
  - If valid=1, ready=0 and no ev: addr and valid are held stable.
  - ev with valid=0, or with valid=1 and ready=1: load the new addr and set valid=1. No gap, no overflow.
  - ev with valid=1 and ready=0: keep the old addr, drop the new one, set overflow=1. overflow stays set until the next accepted start or reset.
  - No ev and a transfer occurs: valid<=0.
- Simultaneous y_zero and z_zero on the same adv cycle: the address uses the old x; x then increments.
- Forced wrap (temp_count=1, temp_zero=1): not a stall, so adv and ev proceed normally.

Test Plan:
1. Reset/idle: rst pulse, then y_zero/z_zero toggled with start=0 -> x=0, addr_valid=0, busy=0, no done.
2. Basic address: BASE_ADDR=0, ROW_STRIDE=30, start, x=2, y=5, z_zero=1, ready=1 -> next cycle addr=65, addr_valid=1; the following cycle addr_valid=0.
3. Full pass: start, then 30 y_zero pulses with no stall and ready=1 -> x steps 0..29, x_zero high on the 30th pulse, x returns to 0, done pulses once, busy falls in the same cycle as done.
4. Stall: temp_count=1, temp_zero=0 with y_zero=1 and z_zero=1 at x=7 -> x stays 7, no new addr. Then temp_zero=1 -> x=8 and an addr event occurs.
5. Backpressure: hold ready=0 and issue two ev -> addr holds the first value and overflow=1. Release ready -> one transfer, then valid=0. Next start clears overflow.
6. DRAIN and reset mid-pass: final adv with valid=1 and ready=0 -> no done until ready=1, then done next cycle. Separately, rst asserted at x=12 -> all outputs zero at once and no done pulse.
